// File: rtl/fp_div.sv
// rtl/fp_div.sv - sequential binary32 divider, restoring radix-2, truncating, flush-to-zero
module fp_div (
    input  logic        fp_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } state_t;

    state_t             state;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic               sign;
    logic signed [9:0]  e;
    logic [23:0]        mb;
    logic [25:0]        r;
    logic [24:0]        q;
    logic [4:0]         cnt;

    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [25:0] r_diff;
    logic        r_ge;

    assign a_exp  = a_reg[30:23];
    assign b_exp  = b_reg[30:23];
    assign a_frac = a_reg[22:0];
    assign b_frac = b_reg[22:0];
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hff) && (a_frac == 23'h0);
    assign b_inf  = (b_exp == 8'hff) && (b_frac == 23'h0);
    assign a_nan  = (a_exp == 8'hff) && (a_frac != 23'h0);
    assign b_nan  = (b_exp == 8'hff) && (b_frac != 23'h0);
    assign r_diff = r - {2'b00, mb};
    assign r_ge   = (r >= {2'b00, mb});

    // Quotient lies in (0.5, 2): a leading zero costs one exponent step
    logic signed [9:0] n_exp;
    logic [22:0]       n_frac;
    always_comb begin
        n_exp  = e;
        n_frac = q[23:1];
        if (!q[24]) begin
            n_exp  = e - 10'sd1;
            n_frac = q[22:0];
        end
    end

    always_ff @(posedge fp_clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            a_reg       <= 32'h0;
            b_reg       <= 32'h0;
            sign        <= 1'b0;
            e           <= 10'sd0;
            mb          <= 24'h0;
            r           <= 26'h0;
            q           <= 25'h0;
            cnt         <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Out         <= 32'h0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        busy  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    sign <= a_reg[31] ^ b_reg[31];
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        Out         <= 32'h7fc00000;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (a_inf) begin
                        Out         <= {a_reg[31] ^ b_reg[31], 8'hff, 23'h0};
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (b_zero) begin
                        Out         <= {a_reg[31] ^ b_reg[31], 8'hff, 23'h0};
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else if (a_zero || b_inf) begin
                        Out         <= {a_reg[31] ^ b_reg[31], 31'h0};
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        e     <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
                        mb    <= {1'b1, b_frac};
                        r     <= {2'b01, a_frac};
                        q     <= 25'h0;
                        cnt   <= 5'd25;
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (r_ge) begin
                        r <= {r_diff[24:0], 1'b0};
                        q <= {q[23:0], 1'b1};
                    end else begin
                        r <= {r[24:0], 1'b0};
                        q <= {q[23:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (n_exp >= 10'sd255) begin
                        Out <= {sign, 8'hff, 23'h0};
                    end else if (n_exp <= 10'sd0) begin
                        Out <= {sign, 31'h0};
                    end else begin
                        Out <= {sign, n_exp[7:0], n_frac};
                    end
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
